load_hash_vector: RTL and testbench
===================================

Name: load_hash_vector

Overview:
- Reader counterpart of the hash-store path: fetches HASH_LENGTH 32-bit words from the hash word memory and reassembles them into a 256-bit hash vector.
- Word k lands in hash_vector[k*32 +: 32], the same word/bit mapping the store path uses when splitting the vector.
- Sits between the hash word memory (synchronous read, 1-cycle latency) and the compression/compare logic.

Parameters:
- HASH_LENGTH, 8, number of 32-bit words per vector; HASH_LENGTH*32 must equal 256.
- WORD_WIDTH, 32, memory word width; fixed at 32.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  level request; rising into IDLE starts a load, deassert aborts or releases
- h_read  output  1  memory read strobe
- h_read_address  output  $clog2(HASH_LENGTH)  memory word address
- h_read_data  input  32  memory read data, valid one cycle after the address is sampled
- hash_vector  output  256  assembled vector
- h_vector_valid  output  1  vector complete; held until enable drops
- busy  output  1  high in READ or DRAIN

Behaviour:
- Reset (reset=0, async): state=IDLE; h_read=0, h_read_address=0, hash_vector=0, h_vector_valid=0, busy=0; capture pipeline flags cleared.
- All outputs are registered.
- FSM states:
  - IDLE: enable=1 sampled -> READ; h_read=1, address=0, hash_vector cleared to 0.
  - READ: address increments by 1 each cycle with h_read=1. After issuing HASH_LENGTH-1 -> DRAIN; h_read=0, address held.
  - DRAIN: capture last word -> DONE; h_vector_valid=1.
  - DONE: hold hash_vector and valid. enable=0 -> IDLE, valid cleared next edge.
- Capture pipeline:
  - Registered pending flag + index track the address issued on the previous cycle.
  - Word k is written into hash_vector[k*32 +: 32] at edge E(k+2), where E0 is the edge sampling enable in IDLE.
- Latency: h_vector_valid high after edge E(HASH_LENGTH+1), i.e. E9 at default. Exactly HASH_LENGTH read strobes per load, addresses 0..HASH_LENGTH-1 in order, no gaps.
- Abort: enable=0 in READ or DRAIN -> IDLE next edge.
  - h_read=0 and busy=0; the pending capture is discarded.
  - h_vector_valid stays 0; partial hash_vector is retained but meaningless.
- Async reset mid-load: immediate return to reset values; no further strobes.
- enable held high in DONE: no re-read. A new load needs enable to drop for at least one cycle.
- Address counter never wraps: it stops at HASH_LENGTH-1.

Optional Feature:
- Macro: LOAD_HASH_BSWAP_EN.
- Defined: each captured word is byte-reversed before placement ({d[7:0],d[15:8],d[23:16],d[31:24]}) for little-endian memories. Timing is unchanged.
- Undefined: words are placed verbatim.

Decomposition:
- Shared package sha256_pkg holds:
  - HASH_WORDS=8, WORD_W=32, HASH_W=256
  - state typedef load_state_t {IDLE, READ, DRAIN, DONE}
  - a word-placement helper (index -> bit offset) shared with the store path
- One sub-module is natural: hash_word_capture, containing the pending flag/index pipeline plus optional byte swap and the vector register. The FSM and address counter stay in the top.

Test Plan:
- Memory preloaded with word k = 32'h1000_0000+k; pulse enable high -> strobes on addresses 0..7 at E1..E8. Valid at E9; hash_vector = {32'h10000007,...,32'h10000000}.
- Hold enable high after DONE for 20 cycles -> no further h_read, vector stable. Drop enable -> valid=0 next edge. Raise again -> new 8-read load with identical result.
- Drop enable after 3 strobes -> h_read=0 and busy=0 next edge, valid never asserts. A restart yields the correct full vector.
- Assert reset low between edges during READ (word 4 pending) -> all outputs 0 immediately, no strobe after release until enable is re-sampled.
- With LOAD_HASH_BSWAP_EN, memory word0 = 32'h6A09E667 -> hash_vector[31:0] = 32'h67E6096A. Latency still E9.
- Randomised memory contents, 100 back-to-back loads -> scoreboard matches the memory image every load, exactly 8 strobes per load.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, load-FSM state encoding and the word-placement helper
// used by both the hash-store and hash-load paths.
package sha256_pkg;

   localparam int HASH_WORDS = 8;
   localparam int WORD_W     = 32;
   localparam int HASH_W     = HASH_WORDS * WORD_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } load_state_t;

   // Word k of the vector always lives at bit offset k*WORD_W.
   function automatic int unsigned word_offset(input int unsigned index);
      return index * WORD_W;
   endfunction

endpackage

// File: rtl/load_hash_vector_if.sv
// Request, memory-read and result signals of the hash-vector loader.
// The slave modport is the loader; master is the requester/memory side.
interface load_hash_vector_if;
   import sha256_pkg::*;

   logic                          enable;
   logic                          h_read;
   logic [$clog2(HASH_WORDS)-1:0] h_read_address;
   logic [WORD_W-1:0]             h_read_data;
   logic [HASH_W-1:0]             hash_vector;
   logic                          h_vector_valid;
   logic                          busy;

   modport slave (
      input  enable,
      input  h_read_data,
      output h_read,
      output h_read_address,
      output hash_vector,
      output h_vector_valid,
      output busy
   );

   modport master (
      output enable,
      output h_read_data,
      input  h_read,
      input  h_read_address,
      input  hash_vector,
      input  h_vector_valid,
      input  busy
   );

endinterface

// File: rtl/load_hash_vector_capture.sv
// Capture pipeline: remembers which word was read last cycle and drops the returning
// data into its vector slot. LOAD_HASH_BSWAP_EN byte-reverses each word on capture.
module load_hash_vector_capture
   import sha256_pkg::*;
#(
   parameter int HASH_LENGTH = HASH_WORDS,
   parameter int WORD_WIDTH  = WORD_W,
   localparam int IDX_W      = $clog2(HASH_LENGTH)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              flush,
   input  logic                              issue,
   input  logic [IDX_W-1:0]                  issue_index,
   input  logic [WORD_WIDTH-1:0]             read_data,
   output logic [HASH_LENGTH*WORD_WIDTH-1:0] hash_vector
);

   logic             pending_reg;
   logic [IDX_W-1:0] index_reg;
   logic [WORD_WIDTH-1:0] placed_word;

`ifdef LOAD_HASH_BSWAP_EN
   assign placed_word = {read_data[7:0], read_data[15:8], read_data[23:16], read_data[31:24]};
`else
   assign placed_word = read_data;
`endif

   // A strobe on the bus this edge means data returns next edge; an abort kills it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_reg <= 1'b0;
         index_reg   <= '0;
      end else begin
         pending_reg <= issue & ~flush;
         index_reg   <= issue_index;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < HASH_LENGTH; gi++) begin : g_slot
         localparam int unsigned OFFSET = word_offset(gi);
         logic [WORD_WIDTH-1:0] word_reg;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               word_reg <= '0;
            end else if (start) begin
               word_reg <= '0;
            end else if (pending_reg && !flush && index_reg == IDX_W'(gi)) begin
               word_reg <= placed_word;
            end
         end

         assign hash_vector[OFFSET +: WORD_WIDTH] = word_reg;
      end
   endgenerate

endmodule

// File: rtl/load_hash_vector.sv
// Hash-vector loader: reads HASH_LENGTH consecutive memory words and assembles them.
// Build option LOAD_HASH_BSWAP_EN selects byte-reversed placement for little-endian memories.
module load_hash_vector
   import sha256_pkg::*;
#(
   parameter int HASH_LENGTH = HASH_WORDS,
   parameter int WORD_WIDTH  = WORD_W
) (
   input  logic              clock,
   input  logic              reset,
   load_hash_vector_if.slave bus
);

   localparam int IDX_W = $clog2(HASH_LENGTH);
   localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(HASH_LENGTH - 1);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_READ  = READ;
   localparam logic [1:0] ST_DRAIN = DRAIN;
   localparam logic [1:0] ST_DONE  = DONE;

   logic [1:0]       state_reg, state_next;
   logic [IDX_W-1:0] addr_reg, addr_next;
   logic             read_reg, read_next;
   logic             valid_reg, valid_next;
   logic             busy_reg, busy_next;
   logic             start, flush;
   logic [HASH_LENGTH*WORD_WIDTH-1:0] vector;

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      read_next  = 1'b0;
      valid_next = valid_reg;
      busy_next  = 1'b0;
      start      = 1'b0;
      flush      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            valid_next = 1'b0;
            if (bus.enable) begin
               state_next = ST_READ;
               addr_next  = '0;
               read_next  = 1'b1;
               busy_next  = 1'b1;
               start      = 1'b1;
            end
         end
         ST_READ: begin
            if (!bus.enable) begin
               state_next = ST_IDLE;
               flush      = 1'b1;
            end else if (addr_reg == LAST_ADDR) begin
               // Last address is being sampled by the memory now; hold it.
               state_next = ST_DRAIN;
               busy_next  = 1'b1;
            end else begin
               addr_next = addr_reg + IDX_W'(1);
               read_next = 1'b1;
               busy_next = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!bus.enable) begin
               state_next = ST_IDLE;
               flush      = 1'b1;
            end else begin
               state_next = ST_DONE;
               valid_next = 1'b1;
            end
         end
         default: begin
            if (!bus.enable) begin
               state_next = ST_IDLE;
               valid_next = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         read_reg  <= 1'b0;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         read_reg  <= read_next;
         valid_reg <= valid_next;
         busy_reg  <= busy_next;
      end
   end

   load_hash_vector_capture #(
      .HASH_LENGTH (HASH_LENGTH),
      .WORD_WIDTH  (WORD_WIDTH)
   ) u_capture (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .flush       (flush),
      .issue       (read_reg),
      .issue_index (addr_reg),
      .read_data   (bus.h_read_data),
      .hash_vector (vector)
   );

   assign bus.h_read         = read_reg;
   assign bus.h_read_address = addr_reg;
   assign bus.hash_vector    = vector;
   assign bus.h_vector_valid = valid_reg;
   assign bus.busy           = busy_reg;

endmodule

// File: tb/tb_load_hash_vector.sv
// Directed + randomised bench for load_hash_vector with a synchronous memory model
// and a scoreboard of expected vectors popped when h_vector_valid rises.
module tb_load_hash_vector;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   load_hash_vector_if bus ();

   load_hash_vector dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0]  mem [8];
   logic [255:0] sb [$];
   logic [255:0] last_exp;
   int pass_cnt   = 0;
   int check_cnt  = 0;
   int strobe_cnt = 0;
   int burst_idx  = 0;
   logic valid_prev = 1'b0;

   initial bus.h_read_data = '0;
   always @(posedge clock) begin
      if (bus.h_read) bus.h_read_data <= mem[bus.h_read_address];
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      check_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic logic [31:0] swap_model(input logic [31:0] w);
`ifdef LOAD_HASH_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic logic [255:0] model_vec();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = swap_model(mem[k]);
      return v;
   endfunction

   // Strobe/address monitor and scoreboard pop on valid rising.
   always @(negedge clock) begin
      if (bus.h_read) begin
         check("addr_seq", 256'(bus.h_read_address), 256'(burst_idx));
         burst_idx++;
         strobe_cnt++;
      end else begin
         burst_idx = 0;
      end
      if (bus.h_vector_valid && !valid_prev) begin
         check("sb_nonempty", 256'(sb.size() > 0), 256'(1));
         if (sb.size() > 0) check("vector", bus.hash_vector, sb.pop_front());
      end
      valid_prev = bus.h_vector_valid;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic run_load(input string tag);
      int n;
      int s0;
      logic seen;
      last_exp = model_vec();
      sb.push_back(last_exp);
      s0 = strobe_cnt;
      n = 0;
      seen = 1'b0;
      bus.enable = 1'b1;
      while (!seen && n < 30) begin
         step(1);
         n++;
         if (bus.h_vector_valid) seen = 1'b1;
      end
      check({tag, "_latency"}, 256'(n), 256'(10));
      check({tag, "_strobes"}, 256'(strobe_cnt - s0), 256'(8));
      $display("load %s: latency=%0d strobes=%0d vector=%h", tag, n, strobe_cnt - s0, bus.hash_vector);
   endtask

   initial begin
      int s0;
      logic valid_seen;
      bus.enable = 1'b0;
      for (int k = 0; k < 8; k++) mem[k] = 32'h1000_0000 + k;
`ifdef LOAD_HASH_BSWAP_EN
      mem[0] = 32'h6A09E667;
`endif

      // Reset state
      #1 reset = 1'b0;
      #1;
      check("rst_h_read", 256'(bus.h_read), 256'(0));
      check("rst_addr", 256'(bus.h_read_address), 256'(0));
      check("rst_vector", bus.hash_vector, 256'(0));
      check("rst_valid", 256'(bus.h_vector_valid), 256'(0));
      check("rst_busy", 256'(bus.busy), 256'(0));
      step(2);
      reset = 1'b1;
      step(1);

      // Basic load
      run_load("basic");
`ifdef LOAD_HASH_BSWAP_EN
      check("bswap_w0", 256'(bus.hash_vector[31:0]), 256'(32'h67E6096A));
`else
      check("basic_const", bus.hash_vector,
            {32'h10000007, 32'h10000006, 32'h10000005, 32'h10000004,
             32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000});
`endif
      check("basic_busy_done", 256'(bus.busy), 256'(0));

      // Hold enable in DONE: no re-read, vector stable
      s0 = strobe_cnt;
      step(20);
      check("hold_strobes", 256'(strobe_cnt - s0), 256'(0));
      check("hold_valid", 256'(bus.h_vector_valid), 256'(1));
      check("hold_vector", bus.hash_vector, last_exp);
      bus.enable = 1'b0;
      step(1);
      check("release_valid", 256'(bus.h_vector_valid), 256'(0));
      $display("hold/release: strobes=%0d valid=%0d", strobe_cnt - s0, bus.h_vector_valid);
      run_load("reload");
      bus.enable = 1'b0;
      step(1);

      // Abort after 3 strobes
      s0 = strobe_cnt;
      bus.enable = 1'b1;
      step(3);
      check("abort_pre_strobes", 256'(strobe_cnt - s0), 256'(3));
      bus.enable = 1'b0;
      step(1);
      check("abort_h_read", 256'(bus.h_read), 256'(0));
      check("abort_busy", 256'(bus.busy), 256'(0));
      valid_seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step(1);
         valid_seen |= bus.h_vector_valid;
      end
      check("abort_no_valid", 256'(valid_seen), 256'(0));
      check("abort_strobes", 256'(strobe_cnt - s0), 256'(3));
      $display("abort: strobes=%0d valid_seen=%0d", strobe_cnt - s0, valid_seen);
      run_load("after_abort");
      bus.enable = 1'b0;
      step(1);

      // Async reset with word 4 pending
      bus.enable = 1'b1;
      step(6);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_h_read", 256'(bus.h_read), 256'(0));
      check("mid_rst_addr", 256'(bus.h_read_address), 256'(0));
      check("mid_rst_vector", bus.hash_vector, 256'(0));
      check("mid_rst_valid", 256'(bus.h_vector_valid), 256'(0));
      check("mid_rst_busy", 256'(bus.busy), 256'(0));
      bus.enable = 1'b0;
      step(2);
      reset = 1'b1;
      s0 = strobe_cnt;
      step(5);
      check("post_rst_strobes", 256'(strobe_cnt - s0), 256'(0));
      check("post_rst_busy", 256'(bus.busy), 256'(0));
      $display("mid-load reset: strobes after release=%0d", strobe_cnt - s0);
      run_load("after_reset");
      bus.enable = 1'b0;
      step(1);

      // Randomised back-to-back loads
      for (int l = 0; l < 100; l++) begin
         for (int k = 0; k < 8; k++) mem[k] = $urandom;
         run_load($sformatf("rand%0d", l));
         bus.enable = 1'b0;
         step(1);
      end

      step(2);
      check("sb_drained", 256'(sb.size()), 256'(0));
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
